// File: rtl/gray_counter.sv
// Registered up/down Gray-code sequence generator with load, terminal-count decode and wrap pulse.
// Define GRAY_COUNTER_SAT_EN to saturate at the sequence ends instead of wrapping.
module gray_counter #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_bin,
  input  logic                  en,
  input  logic                  dir,
  output logic [DATA_WIDTH-1:0] bin,
  output logic [DATA_WIDTH-1:0] gray,
  output logic                  tc,
  output logic                  wrap
);

  localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

  logic [DATA_WIDTH-1:0] bin_q, bin_d;
  logic [DATA_WIDTH-1:0] gray_q, gray_d;
  logic                  wrap_q, wrap_d;

  // tc depends only on the registered index and the live dir, never on load/en.
  assign tc = dir ? (bin_q == '0) : (bin_q == '1);

  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
    if (load) begin
      bin_d = load_bin;
    end else if (en) begin
`ifdef GRAY_COUNTER_SAT_EN
      if (!tc) begin
        bin_d = dir ? (bin_q - ONE) : (bin_q + ONE);
      end
`else
      bin_d  = dir ? (bin_q - ONE) : (bin_q + ONE);
      wrap_d = tc;
`endif
    end
    // Encode from the next index so gray and bin land on the same edge.
    gray_d = bin_d ^ (bin_d >> 1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bin_q  <= '0;
      gray_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
    end
  end

  assign bin  = bin_q;
  assign gray = gray_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_gray_counter.sv
// Directed self-checking bench for gray_counter at DATA_WIDTH=4.
module tb_gray_counter;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         resetn;
  logic         load;
  logic [W-1:0] load_bin;
  logic         en;
  logic         dir;
  logic [W-1:0] bin;
  logic [W-1:0] gray;
  logic         tc;
  logic         wrap;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] gray_tbl [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                  4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
  logic [W-1:0] prev_gray;

  gray_counter #(.DATA_WIDTH(W)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .load     (load),
    .load_bin (load_bin),
    .en       (en),
    .dir      (dir),
    .bin      (bin),
    .gray     (gray),
    .tc       (tc),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn = 1'b0; load = 1'b0; load_bin = '0; en = 1'b0; dir = 1'b0;
    #2;
    chk("rst_bin", 32'(bin), 32'h0);
    chk("rst_gray", 32'(gray), 32'h0);
    chk("rst_wrap", 32'(wrap), 32'h0);
    chk("rst_tc_up", 32'(tc), 32'h0);
    dir = 1'b1; #1;
    chk("rst_tc_down", 32'(tc), 32'h1);
    dir = 1'b0;

    // Up sequence through the wrap
    step();
    resetn = 1'b1; en = 1'b1;
    prev_gray = gray;
    for (int i = 1; i <= 16; i++) begin
      step();
      chk("up_gray", 32'(gray), 32'(gray_tbl[i % 16]));
      chk("up_bin", 32'(bin), 32'(i % 16));
      chk("up_wrap", 32'(wrap), (i == 16) ? 32'h1 : 32'h0);
      chk("up_tc", 32'(tc), ((i % 16) == 15) ? 32'h1 : 32'h0);
      chk("up_onebit", 32'($countones(gray ^ prev_gray)), 32'h1);
      prev_gray = gray;
    end
    en = 1'b0;

    // Down wrap from reset
    resetn = 1'b0; #1; resetn = 1'b1;
    dir = 1'b1; #1;
    chk("dn_tc_at0", 32'(tc), 32'h1);
    en = 1'b1;
    step();
    en = 1'b0;
    chk("dn_bin", 32'(bin), 32'hF);
    chk("dn_gray", 32'(gray), 32'h8);
    chk("dn_wrap", 32'(wrap), 32'h1);
    chk("dn_tc_after", 32'(tc), 32'h0);
    step();
    chk("dn_wrap_clr", 32'(wrap), 32'h0);
    chk("dn_hold_bin", 32'(bin), 32'hF);

    // Load priority over en
    load = 1'b1; load_bin = 4'h3; dir = 1'b0;
    step();
    chk("ld3_bin", 32'(bin), 32'h3);
    chk("ld3_gray", 32'(gray), 32'h2);
    load_bin = 4'h5; en = 1'b1;
    step();
    load = 1'b0;
    chk("ldpri_bin", 32'(bin), 32'h5);
    chk("ldpri_gray", 32'(gray), 32'h7);
    chk("ldpri_wrap", 32'(wrap), 32'h0);

    // Step to 6, hold, then step down
    step();
    en = 1'b0;
    chk("to6_bin", 32'(bin), 32'h6);
    chk("to6_gray", 32'(gray), 32'h5);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_bin", 32'(bin), 32'h6);
      chk("hold_gray", 32'(gray), 32'h5);
    end
    en = 1'b1; dir = 1'b1;
    step();
    en = 1'b0;
    chk("flip_bin", 32'(bin), 32'h5);
    chk("flip_gray", 32'(gray), 32'h7);

    // Load at all-ones, step up, then load over a would-be wrap
    load = 1'b1; load_bin = 4'hF; dir = 1'b0;
    step();
    load = 1'b0; en = 1'b1;
    chk("ldF_tc", 32'(tc), 32'h1);
    step();
`ifdef GRAY_COUNTER_SAT_EN
    chk("end_bin", 32'(bin), 32'hF);
    chk("end_wrap", 32'(wrap), 32'h0);
`else
    chk("end_bin", 32'(bin), 32'h0);
    chk("end_wrap", 32'(wrap), 32'h1);
`endif
    load = 1'b1; load_bin = 4'hF;
    step();
    load = 1'b0; en = 1'b0;
    chk("ldwrap_bin", 32'(bin), 32'hF);
    chk("ldwrap_wrap", 32'(wrap), 32'h0);

    // Async reset mid-count
    load = 1'b1; load_bin = 4'hA;
    step();
    load = 1'b0; en = 1'b1; dir = 1'b0;
    chk("ldA_gray", 32'(gray), 32'hF);
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_bin", 32'(bin), 32'h0);
    chk("arst_gray", 32'(gray), 32'h0);
    chk("arst_wrap", 32'(wrap), 32'h0);
    step();
    chk("arst_hold_bin", 32'(bin), 32'h0);
    chk("arst_hold_gray", 32'(gray), 32'h0);
    resetn = 1'b1;
    step();
    en = 1'b0;
    chk("post_rst_bin", 32'(bin), 32'h1);
    chk("post_rst_gray", 32'(gray), 32'h1);

`ifdef GRAY_COUNTER_SAT_EN
    // Saturation at the top, then reverse
    load = 1'b1; load_bin = 4'hF;
    step();
    load = 1'b0; en = 1'b1; dir = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("sat_bin", 32'(bin), 32'hF);
      chk("sat_gray", 32'(gray), 32'h8);
      chk("sat_wrap", 32'(wrap), 32'h0);
    end
    dir = 1'b1;
    step();
    en = 1'b0;
    chk("sat_rev_bin", 32'(bin), 32'hE);
    chk("sat_rev_gray", 32'(gray), 32'h9);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
